vga_timing_gen: RTL and testbench

- Raster timing source for the 1280x1024@60 Hz VGA text display, clocked at the 108 MHz pixel clock.
- Generates the `line`/`column` coordinates consumed by the display/pixel-colour logic.
- Takes the colour that logic returns for those coordinates and drives the VGA connector: RGB, HSYNC and VSYNC.
- Registers colour and syncs together, so all pins change on the same clock edge.

---
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_timing_gen.sv | 110 +++++++++++
 tb/tb_vga_timing_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster bus between vga_timing_gen and the display/pixel-colour logic.
// With VGA_TESTPATTERN_EN defined, the interface also carries pattern_en.
interface vga_timing_gen_if;
    logic [11:0] line;
    logic [11:0] column;
    logic        video_on;
    logic        frame_start;
    logic [11:0] RGBsig;
    logic [11:0] rgb_out;
    logic        hsync;
    logic        vsync;
`ifdef VGA_TESTPATTERN_EN
    logic        pattern_en;

    modport master (
        output line, column, video_on, frame_start, rgb_out, hsync, vsync,
        input  RGBsig, pattern_en
    );
    modport slave (
        input  line, column, video_on, frame_start, rgb_out, hsync, vsync,
        output RGBsig, pattern_en
    );
`else
    modport master (
        output line, column, video_on, frame_start, rgb_out, hsync, vsync,
        input  RGBsig
    );
    modport slave (
        input  line, column, video_on, frame_start, rgb_out, hsync, vsync,
        output RGBsig
    );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source for 1280x1024@60 (108 MHz): counters, syncs and registered colour.
// Optional colour-bar generator enabled by defining VGA_TESTPATTERN_EN.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 48,
    parameter int unsigned H_SYNC   = 112,
    parameter int unsigned H_BP     = 248,
    parameter int unsigned V_ACTIVE = 1024,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 38,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1
) (
    input logic             clk,
    input logic             reset,
    vga_timing_gen_if.master vga
);

    localparam logic [11:0] H_ACT_W   = 12'(H_ACTIVE);
    localparam logic [11:0] H_TOTAL_W = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT_W   = 12'(V_ACTIVE);
    localparam logic [11:0] V_TOTAL_W = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] VS_START  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] col_q,  col_d;
    logic [11:0] line_q, line_d;
    logic        col_last;
    logic        line_last;
    logic        active;
    logic        hs_win;
    logic        vs_win;
    logic [11:0] pix_src;
    logic [11:0] rgb_d;
    logic [11:0] rgb_q;
    logic        hs_q;
    logic        vs_q;

    // Raster counters: column free-runs, line only advances on the column wrap.
    always_comb begin
        col_last  = (col_q == H_TOTAL_W - 12'd1);
        line_last = (line_q == V_TOTAL_W - 12'd1);
        col_d     = col_q + 12'd1;
        line_d    = line_q;
        if (col_last) begin
            col_d  = '0;
            line_d = line_last ? '0 : line_q + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q  <= '0;
            line_q <= '0;
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
        end
    end

    always_comb begin
        active = (col_q < H_ACT_W) && (line_q < V_ACT_W);
        hs_win = (col_q >= HS_START) && (col_q < HS_END);
        vs_win = (line_q >= VS_START) && (line_q < VS_END);
    end

`ifdef VGA_TESTPATTERN_EN
    logic [2:0]  bar_idx;
    logic [11:0] bar_rgb;

    always_comb begin
        bar_idx = col_q[10:8];
        bar_rgb = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
        pix_src = vga.pattern_en ? bar_rgb : vga.RGBsig;
    end
`else
    always_comb begin
        pix_src = vga.RGBsig;
    end
`endif

    always_comb begin
        rgb_d = active ? pix_src : '0;
    end

    // Colour and syncs share one register stage so all pins move on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_win ? HS_POL : ~HS_POL;
            vs_q  <= vs_win ? VS_POL : ~VS_POL;
        end
    end

    assign vga.line        = line_q;
    assign vga.column      = col_q;
    assign vga.video_on    = active;
    assign vga.frame_start = (col_q == '0) && (line_q == '0);
    assign vga.rgb_out     = rgb_q;
    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing, scaled-down instance for frame timing.
module tb_vga_timing_gen;

    logic clk;
    logic reset;
    int unsigned total;
    int unsigned bad;

    vga_timing_gen_if vd ();
    vga_timing_gen_if vs ();

    vga_timing_gen dut_d (
        .clk   (clk),
        .reset (reset),
        .vga   (vd)
    );

    // Scaled raster: H_TOTAL=25, V_TOTAL=10, frame=250 clocks, hsync cols 18..20, vsync lines 7..8.
    vga_timing_gen #(
        .H_ACTIVE (16),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (4),
        .V_ACTIVE (6),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .HS_POL   (1'b1),
        .VS_POL   (1'b1)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .vga   (vs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int unsigned k;
        logic [11:0] rgb_in;
        logic [11:0] col;
        logic [11:0] line;
        logic        hs;
        logic        vid;
        logic [11:0] rgb;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".d.line"},  32'(vd.line), 32'd0);
        chk({tag, ".d.col"},   32'(vd.column), 32'd0);
        chk({tag, ".d.rgb"},   32'(vd.rgb_out), 32'd0);
        chk({tag, ".d.hs"},    32'(vd.hsync), 32'd0);
        chk({tag, ".d.vs"},    32'(vd.vsync), 32'd0);
        chk({tag, ".d.fs"},    32'(vd.frame_start), 32'd1);
        chk({tag, ".s.line"},  32'(vs.line), 32'd0);
        chk({tag, ".s.col"},   32'(vs.column), 32'd0);
        chk({tag, ".s.rgb"},   32'(vs.rgb_out), 32'd0);
        chk({tag, ".s.hs"},    32'(vs.hsync), 32'd0);
        chk({tag, ".s.vs"},    32'(vs.vsync), 32'd0);
        chk({tag, ".s.fs"},    32'(vs.frame_start), 32'd1);
    endtask

    initial begin
        int unsigned k;
        int unsigned n;
        int unsigned cnt;
        int unsigned first;
        bit          found;

        total = 0;
        bad   = 0;
        vd.RGBsig = 12'hABC;
        vs.RGBsig = 12'hABC;
`ifdef VGA_TESTPATTERN_EN
        vd.pattern_en = 1'b0;
        vs.pattern_en = 1'b0;
`endif

        //          k     rgb_in   col       line   hs    vid   rgb
        vecs[0]  = '{1,    12'hABC, 12'd1,    12'd0, 1'b0, 1'b1, 12'hABC};
        vecs[1]  = '{2,    12'h123, 12'd2,    12'd0, 1'b0, 1'b1, 12'h123};
        vecs[2]  = '{1280, 12'hABC, 12'd1280, 12'd0, 1'b0, 1'b0, 12'hABC};
        vecs[3]  = '{1281, 12'hFFF, 12'd1281, 12'd0, 1'b0, 1'b0, 12'h000};
        vecs[4]  = '{1328, 12'hABC, 12'd1328, 12'd0, 1'b0, 1'b0, 12'h000};
        vecs[5]  = '{1329, 12'hABC, 12'd1329, 12'd0, 1'b1, 1'b0, 12'h000};
        vecs[6]  = '{1440, 12'hABC, 12'd1440, 12'd0, 1'b1, 1'b0, 12'h000};
        vecs[7]  = '{1441, 12'hABC, 12'd1441, 12'd0, 1'b0, 1'b0, 12'h000};
        vecs[8]  = '{1687, 12'hABC, 12'd1687, 12'd0, 1'b0, 1'b0, 12'h000};
        vecs[9]  = '{1688, 12'hABC, 12'd0,    12'd1, 1'b0, 1'b1, 12'h000};
        vecs[10] = '{1689, 12'h5A5, 12'd1,    12'd1, 1'b0, 1'b1, 12'h5A5};

        // Reset held 5 cycles
        reset = 1'b1;
        #1;
        repeat (5) tick();
        chk_reset_vals("rst");

        @(negedge clk);
        reset = 1'b0;
        k = 0;

        foreach (vecs[i]) begin
            vd.RGBsig = vecs[i].rgb_in;
            while (k < vecs[i].k) begin
                tick();
                k++;
            end
            chk($sformatf("vec%0d.col", i),  32'(vd.column),   32'(vecs[i].col));
            chk($sformatf("vec%0d.line", i), 32'(vd.line),     32'(vecs[i].line));
            chk($sformatf("vec%0d.hs", i),   32'(vd.hsync),    32'(vecs[i].hs));
            chk($sformatf("vec%0d.vid", i),  32'(vd.video_on), 32'(vecs[i].vid));
            chk($sformatf("vec%0d.rgb", i),  32'(vd.rgb_out),  32'(vecs[i].rgb));
            chk($sformatf("vec%0d.vs", i),   32'(vd.vsync),    32'd0);
            chk($sformatf("vec%0d.fs", i),   32'(vd.frame_start), 32'd0);
        end

        // hsync width over one full line of the full-size raster
        vd.RGBsig = 12'hABC;
        cnt = 0;
        for (int i = 0; i < 1688; i++) begin
            tick();
            if (vd.hsync) cnt++;
        end
        chk("d.hs_width", 32'(cnt), 32'd112);

`ifdef VGA_TESTPATTERN_EN
        vd.pattern_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 1700 && !found; i++) begin
            tick();
            if (vd.column == 12'd200) chk("pat.bar0", 32'(vd.rgb_out), 32'h000);
            if (vd.column == 12'd300) begin
                chk("pat.bar1", 32'(vd.rgb_out), 32'h00F);
                found = 1'b1;
            end
        end
        chk("pat.reached", 32'(found), 32'd1);
        vd.pattern_en = 1'b0;
`endif

        // Scaled raster: locate a frame_start pulse
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (vs.frame_start) found = 1'b1;
        end
        chk("s.fs_found", 32'(found), 32'd1);

        // Over the next frame: vsync width/onset, blanking, frame period
        cnt   = 0;
        first = 0;
        n     = 0;
        k     = 0;
        found = 1'b0;
        for (int j = 1; j <= 250; j++) begin
            tick();
            if (vs.vsync) begin
                cnt++;
                if (first == 0) first = j;
            end
            if (vs.rgb_out != 12'h000) begin
                n++;
                if (vs.rgb_out != 12'hABC) k++;
            end
            if (j == 1) chk("s.fs_width", 32'(vs.frame_start), 32'd0);
            if (vs.frame_start && !found) begin
                found = 1'b1;
                chk("s.fs_period", 32'(j), 32'd250);
            end
        end
        chk("s.fs_seen", 32'(found), 32'd1);
        chk("s.vs_width", 32'(cnt), 32'd50);
        chk("s.vs_first", 32'(first), 32'd176);
        chk("s.active_px", 32'(n), 32'd96);
        chk("s.bad_colour", 32'(k), 32'd0);

        // Asynchronous reset mid-frame at (line 3, column 10)
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (vs.line == 12'd3 && vs.column == 12'd10) found = 1'b1;
        end
        chk("s.mid_found", 32'(found), 32'd1);
        chk("s.mid_rgb_pre", 32'(vs.rgb_out), 32'hABC);
        #3;
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;

        found = 1'b0;
        for (int j = 1; j <= 400 && !found; j++) begin
            tick();
            if (j == 1) chk("s.restart_col", 32'(vs.column), 32'd1);
            if (vs.frame_start) begin
                found = 1'b1;
                chk("s.restart_period", 32'(j), 32'd250);
            end
        end
        chk("s.restart_seen", 32'(found), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
